// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample tick count and
// default frame parameters, used by both transmitter and receiver.
// Optional macro UART_TX_PARITY_EN adds the parity state to the encoding.
package uart_pkg;

  localparam int unsigned OVERSAMPLE         = 16;
  localparam int unsigned DATA_WIDTH_DEFAULT = 8;
  localparam int unsigned SB_TICK_DEFAULT    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with one-entry holding register for back-to-back frames.
// Frame: start(0), data LSB first, [even parity], stop(1) of SB_TICK ticks.
// Optional macro UART_TX_PARITY_EN inserts an even parity bit after the data.
// Ports:
//   clk                   rising-edge clock
//   reset_in              asynchronous active-low reset
//   s_tick                one-clk pulse at 16x baud
//   transmitter_start     send request (accepted when ready is high)
//   transmitter_data_in   frame payload
//   transmitter_ready     holding register empty
//   transmitter_busy      a frame is on the line
//   transmitter_done_tick one-clk pulse at end of stop bit
//   transmitter_out       registered serial line, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned data_width = DATA_WIDTH_DEFAULT,
  parameter int unsigned SB_TICK    = SB_TICK_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  transmitter_start,
  input  logic [data_width-1:0] transmitter_data_in,
  output logic                  transmitter_ready,
  output logic                  transmitter_busy,
  output logic                  transmitter_done_tick,
  output logic                  transmitter_out
);

  localparam int unsigned SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int unsigned NW = $clog2(data_width);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(data_width - 1);

  uart_state_t           state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [data_width-1:0] b_q, b_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
  logic                  accept;
  logic                  done;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign accept = transmitter_start & ~hold_full_q;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      n_q         <= n_d;
      b_q         <= b_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    if (accept && state_q != ST_IDLE) begin
      hold_d      = transmitter_data_in;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          s_d     = '0;
          b_d     = transmitter_data_in;
`ifdef UART_TX_PARITY_EN
          par_d   = ^transmitter_data_in;
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = ST_DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = ST_STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            done = 1'b1;
            s_d  = '0;
            // Chain straight into the next start bit: queued data first,
            // otherwise a request arriving on this very cycle bypasses the
            // holding register.
            if (hold_full_q) begin
              state_d     = ST_START;
              b_d         = hold_q;
              hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
              par_d       = ^hold_q;
`endif
            end else if (accept) begin
              state_d     = ST_START;
              b_d         = transmitter_data_in;
              hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
              par_d       = ^transmitter_data_in;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line value follows the next state so it is registered with no glitch.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign transmitter_ready     = ~hold_full_q;
  assign transmitter_busy      = (state_q != ST_IDLE);
  assign transmitter_done_tick = done;
  assign transmitter_out       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames, back-to-back chaining,
// tick stall, mid-frame reset and randomized traffic against a frame model.
module tb_uart_tx;

  localparam int DW  = 8;
  localparam int SBT = 16;

  logic          clk = 1'b0;
  logic          reset_in = 1'b0;
  logic          s_tick = 1'b0;
  logic          transmitter_start = 1'b0;
  logic [DW-1:0] transmitter_data_in = '0;
  logic          transmitter_ready;
  logic          transmitter_busy;
  logic          transmitter_done_tick;
  logic          transmitter_out;

  uart_tx #(.data_width(DW), .SB_TICK(SBT)) dut (
    .clk                   (clk),
    .reset_in              (reset_in),
    .s_tick                (s_tick),
    .transmitter_start     (transmitter_start),
    .transmitter_data_in   (transmitter_data_in),
    .transmitter_ready     (transmitter_ready),
    .transmitter_busy      (transmitter_busy),
    .transmitter_done_tick (transmitter_done_tick),
    .transmitter_out       (transmitter_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator: one pulse every tick_period clocks, suppressible.
  int tick_period = 4;
  bit tick_pause  = 1'b0;
  int tick_cnt    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (tick_cnt >= tick_period - 1) begin
      tick_cnt = 0;
      s_tick   = !tick_pause;
    end else begin
      tick_cnt++;
      s_tick = 1'b0;
    end
  end

  // Reference: frames accepted but not finished (at most one sending plus one queued).
  logic          line_q[$];
  logic [DW-1:0] exp_bytes[$];
  int            inflight = 0;
  int            done_cnt = 0;
  bit            acc;

  always @(negedge clk) begin
    if (reset_in) begin
      acc = transmitter_start && (inflight < 2);
      check_eq("ready", transmitter_ready, inflight < 2);
      check_eq("busy", transmitter_busy, inflight > 0);
      if (s_tick && transmitter_busy) line_q.push_back(transmitter_out);
      if (transmitter_done_tick) done_cnt++;
      if (acc) exp_bytes.push_back(transmitter_data_in);
      inflight = inflight + int'(acc) - int'(transmitter_done_tick);
    end
  end

  task automatic send(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    transmitter_start   = 1'b1;
    transmitter_data_in = d;
    @(posedge clk);
    #1;
    transmitter_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((transmitter_busy || inflight != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check_eq("idle_timeout", n < 5000, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_samples(input int cnt);
    int n = 0;
    while (line_q.size() < cnt && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq("sample_timeout", n < 3000, 1);
  endtask

  // Each tick seen while busy must carry the frame bit expected at that point.
  task automatic verify(input string tag);
    logic          bits[$];
    int            lens[$];
    logic [DW-1:0] d;
    logic [63:0]   got, exp;
    int            k = 0;
    foreach (exp_bytes[f]) begin
      d = exp_bytes[f];
      bits.push_back(1'b0); lens.push_back(16);
      for (int i = 0; i < DW; i++) begin
        bits.push_back(d[i]); lens.push_back(16);
      end
`ifdef UART_TX_PARITY_EN
      bits.push_back(^d); lens.push_back(16);
`endif
      bits.push_back(1'b1); lens.push_back(SBT);
    end
    foreach (bits[j]) begin
      got = '0;
      exp = '0;
      for (int t = 0; t < lens[j]; t++) begin
        got[t] = (k < line_q.size()) ? line_q[k] : 1'bx;
        exp[t] = bits[j];
        k++;
      end
      check_eq($sformatf("%s bit%0d", tag, j), got, exp);
    end
    check_eq({tag, " len"}, line_q.size(), k);
    check_eq({tag, " done"}, done_cnt, exp_bytes.size());
    line_q.delete();
    exp_bytes.delete();
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a5_line;
    int         n;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst out", transmitter_out, 1);
    check_eq("rst ready", transmitter_ready, 1);
    check_eq("rst busy", transmitter_busy, 0);
    check_eq("rst done", transmitter_done_tick, 0);
    reset_in = 1'b1;

    // Single 0xA5 frame with s_tick every 4 clocks
    tick_period = 4;
    send(8'hA5);
    wait_idle();
`ifndef UART_TX_PARITY_EN
    a5_line = '0;
    for (int b = 0; b < 10; b++)
      if (b * 16 + 8 < line_q.size()) a5_line[b] = line_q[b * 16 + 8];
    check_eq("a5 line", a5_line, 10'b1101001010);
`endif
    verify("a5");

    send(8'h07);
    wait_idle();
    verify("x07");

    // Back-to-back with a third request while holding is full
    @(posedge clk);
    #1;
    transmitter_start = 1'b1; transmitter_data_in = 8'h55;
    @(posedge clk);
    #1;
    transmitter_data_in = 8'h0F;
    @(posedge clk);
    #1;
    transmitter_data_in = 8'hC3;
    @(posedge clk);
    #1;
    transmitter_start = 1'b0;
    check_eq("b2b ready low", transmitter_ready, 0);
    wait_idle();
    verify("b2b");

    // Request arrives exactly on the stop-end cycle with holding empty
    send(8'h96);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #2;
      n++;
      if (transmitter_done_tick) break;
    end
    check_eq("stopend_timeout", n < 3000, 1);
    transmitter_start = 1'b1; transmitter_data_in = 8'h3B;
    @(posedge clk);
    #1;
    transmitter_start = 1'b0;
    wait_idle();
    verify("stopend");

    // s_tick stalled for 100 clocks in the middle of the start bit
    send(8'h5A);
    wait_samples(6);
    @(posedge clk);
    #3;
    tick_pause = 1'b1;
    n = line_q.size();
    repeat (100) @(posedge clk);
    #3;
    check_eq("pause line", transmitter_out, 0);
    check_eq("pause samples", line_q.size(), n);
    tick_pause = 1'b0;
    wait_idle();
    verify("pause");

    // Reset during data bit 3
    send(8'hF0);
    wait_samples(16 + 3 * 16 + 8);
    @(posedge clk);
    #3;
    reset_in = 1'b0;
    #1;
    check_eq("mid rst out", transmitter_out, 1);
    check_eq("mid rst ready", transmitter_ready, 1);
    check_eq("mid rst busy", transmitter_busy, 0);
    check_eq("mid rst done", transmitter_done_tick, 0);
    line_q.delete();
    exp_bytes.delete();
    inflight = 0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_in = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_eq("no done after rst", done_cnt, 0);
    check_eq("no line after rst", line_q.size(), 0);
    check_eq("idle out after rst", transmitter_out, 1);
    send(8'h3C);
    wait_idle();
    verify("post_rst");

    // Randomized bursts
    for (int r = 0; r < 12; r++) begin
      int nf;
      tick_period = $urandom_range(1, 4);
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        repeat ($urandom_range(0, 300)) @(posedge clk);
        @(posedge clk);
        #1;
        transmitter_start   = 1'b1;
        transmitter_data_in = DW'($urandom);
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
        transmitter_start = 1'b0;
      end
      wait_idle();
      verify($sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
